mochila_ext_slave_cut: RTL and testbench



---
 rtl/mochila_ext_slave_cut.sv | 158 +++++++++++++++
 tb/tb_mochila_ext_slave_cut.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mochila_ext_slave_cut.sv
// Registered OBI cut between the cluster external-slave port and the outer fabric,
// with outstanding tracking, registered responses and a response watchdog.
package mochila_ext_slave_cut_pkg;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
  } obi_resp_t;
endpackage

module mochila_ext_slave_cut
  import mochila_ext_slave_cut_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1),
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  obi_req_t         slv_req_i,
  output obi_resp_t        slv_resp_o,
  output obi_req_t         mst_req_o,
  input  obi_resp_t        mst_resp_i,
  input  logic             clr_err_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             timeout_o,
  output logic             unexp_rvalid_o
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                timeout_q, timeout_d;
  logic                unexp_q, unexp_d;
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic mst_req_c, mst_fire_c, slv_gnt_c, slv_fire_c;
  logic rsp_dec_c, unexp_set_c, timeout_set_c;

  // Slot FSM, outstanding counter, watchdog and error flags
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    be_d          = be_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    outstanding_d = outstanding_q;
    wdog_d        = wdog_q;
    rdata_d       = rdata_q;

    mst_req_c  = (state_q == FULL) && (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    mst_fire_c = mst_req_c && mst_resp_i.gnt;
    slv_gnt_c  = slv_req_i.req && ((state_q == EMPTY) || mst_fire_c);
    slv_fire_c = slv_req_i.req && slv_gnt_c;

    case (state_q)
      EMPTY:   if (slv_fire_c) state_d = FULL;
      FULL:    if (mst_fire_c && !slv_fire_c) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (slv_fire_c) begin
      we_d    = slv_req_i.we;
      be_d    = slv_req_i.be;
      addr_d  = slv_req_i.addr;
      wdata_d = slv_req_i.wdata;
    end

    rsp_dec_c   = mst_resp_i.rvalid && (outstanding_q != '0);
    unexp_set_c = mst_resp_i.rvalid && (outstanding_q == '0);
    case ({mst_fire_c, rsp_dec_c})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // Counts cycles that end with work outstanding and no response; saturates at the limit
    if ((outstanding_d == '0) || mst_resp_i.rvalid) begin
      wdog_d = '0;
    end else if (wdog_q != WDOG_W'(TIMEOUT_CYCLES - 1)) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
    timeout_set_c = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 2)) &&
                    (wdog_d == WDOG_W'(TIMEOUT_CYCLES - 1));

    timeout_d = timeout_set_c ? 1'b1 : (clr_err_i ? 1'b0 : timeout_q);
    unexp_d   = unexp_set_c   ? 1'b1 : (clr_err_i ? 1'b0 : unexp_q);

    if (mst_resp_i.rvalid) rdata_d = mst_resp_i.rdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= EMPTY;
      we_q          <= 1'b0;
      be_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      outstanding_q <= '0;
      wdog_q        <= '0;
      timeout_q     <= 1'b0;
      unexp_q       <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      be_q          <= be_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      outstanding_q <= outstanding_d;
      wdog_q        <= wdog_d;
      timeout_q     <= timeout_d;
      unexp_q       <= unexp_d;
      rvalid_q      <= mst_resp_i.rvalid;
      rdata_q       <= rdata_d;
    end
  end

  // Output assembly
  always_comb begin
    mst_req_o        = '0;
    mst_req_o.req    = mst_req_c;
    mst_req_o.we     = we_q;
    mst_req_o.be     = be_q;
    mst_req_o.addr   = addr_q;
    mst_req_o.wdata  = wdata_q;
    slv_resp_o        = '0;
    slv_resp_o.gnt    = slv_gnt_c;
    slv_resp_o.rvalid = rvalid_q;
    slv_resp_o.rdata  = rdata_q;
  end

  assign outstanding_o  = outstanding_q;
  assign timeout_o      = timeout_q;
  assign unexp_rvalid_o = unexp_q;

endmodule

// File: tb/tb_mochila_ext_slave_cut.sv
// Randomized bench for mochila_ext_slave_cut against a transaction-level reference model.
module tb_mochila_ext_slave_cut;
  import mochila_ext_slave_cut_pkg::*;

  localparam int MAXO = 4;
  localparam int TMO  = 16;
  localparam int CW   = $clog2(MAXO + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  obi_req_t      slv_req_i;
  obi_resp_t     slv_resp_o;
  obi_req_t      mst_req_o;
  obi_resp_t     mst_resp_i;
  logic          clr_err_i;
  logic [CW-1:0] outstanding_o;
  logic          timeout_o;
  logic          unexp_rvalid_o;

  always #5 clk_i = ~clk_i;

  mochila_ext_slave_cut #(
    .MAX_OUTSTANDING(MAXO),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .slv_req_i     (slv_req_i),
    .slv_resp_o    (slv_resp_o),
    .mst_req_o     (mst_req_o),
    .mst_resp_i    (mst_resp_i),
    .clr_err_i     (clr_err_i),
    .outstanding_o (outstanding_o),
    .timeout_o     (timeout_o),
    .unexp_rvalid_o(unexp_rvalid_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: accepted-but-not-issued requests, issued-not-answered count,
  // quiet cycles since busy/last response, sticky flags, last forwarded response.
  obi_req_t    pend[$];
  int          cnt, quiet, cyc, peak, accepted;
  bit          m_tmo, m_unexp, m_rv, obs_tmo;
  logic [31:0] m_rd;

  // Fabric stimulus: due cycle of each issued transaction's response
  int fab[$];
  bit auto_rsp;
  int rsp_pct, dly_lo, dly_hi;

  task automatic model_reset();
    pend.delete();
    cnt = 0; quiet = 0; m_tmo = 0; m_unexp = 0; m_rv = 0; m_rd = '0;
  endtask

  task automatic drive(input bit req, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit gnt, input bit clr);
    slv_req_i.req    = req;
    slv_req_i.we     = we;
    slv_req_i.be     = be;
    slv_req_i.addr   = addr;
    slv_req_i.wdata  = wdata;
    mst_resp_i.gnt   = gnt;
    mst_resp_i.rvalid = 1'b0;
    mst_resp_i.rdata = $urandom;
    clr_err_i        = clr;
    if (auto_rsp && fab.size() > 0 && fab[0] <= cyc && int'($urandom_range(0, 99)) < rsp_pct) begin
      mst_resp_i.rvalid = 1'b1;
      void'(fab.pop_front());
    end
  endtask

  task automatic force_rv(input logic [31:0] rd);
    mst_resp_i.rvalid = 1'b1;
    mst_resp_i.rdata  = rd;
    if (fab.size() > 0) void'(fab.pop_front());
  endtask

  task automatic idle(input bit gnt);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gnt, 1'b0);
  endtask

  task automatic rnd_req(input bit gnt);
    drive(1'b1, 1'($urandom), 4'($urandom), $urandom, $urandom, gnt, 1'b0);
  endtask

  // Compare one cycle at the falling edge, then advance the model
  task automatic step();
    bit exp_req, fire, exp_gnt, rv, uset, tset;
    @(negedge clk_i);
    exp_req = (pend.size() > 0) && (cnt < MAXO);
    check("mst_req", 64'(mst_req_o.req), 64'(exp_req));
    if (exp_req) begin
      check("mst_addr",  64'(mst_req_o.addr),  64'(pend[0].addr));
      check("mst_wdata", 64'(mst_req_o.wdata), 64'(pend[0].wdata));
      check("mst_be",    64'(mst_req_o.be),    64'(pend[0].be));
      check("mst_we",    64'(mst_req_o.we),    64'(pend[0].we));
    end
    fire    = exp_req && mst_resp_i.gnt;
    exp_gnt = slv_req_i.req && ((pend.size() == 0) || fire);
    check("slv_gnt",     64'(slv_resp_o.gnt),    64'(exp_gnt));
    check("slv_rvalid",  64'(slv_resp_o.rvalid), 64'(m_rv));
    check("slv_rdata",   64'(slv_resp_o.rdata),  64'(m_rd));
    check("outstanding", 64'(outstanding_o),     64'(cnt));
    check("timeout",     64'(timeout_o),         64'(m_tmo));
    check("unexp",       64'(unexp_rvalid_o),    64'(m_unexp));
    obs_tmo = timeout_o;
    if (int'(outstanding_o) > peak) peak = int'(outstanding_o);

    rv = mst_resp_i.rvalid;
    if (fire) begin
      void'(pend.pop_front());
      fab.push_back(cyc + int'($urandom_range(dly_lo, dly_hi)));
    end
    if (slv_req_i.req && exp_gnt) begin
      pend.push_back(slv_req_i);
      accepted++;
    end
    uset  = rv && (cnt == 0);
    cnt   = cnt + (fire ? 1 : 0) - ((rv && cnt > 0) ? 1 : 0);
    quiet = (cnt == 0 || rv) ? 0 : quiet + 1;
    tset  = (quiet == TMO - 1);
    m_tmo   = tset ? 1'b1 : (clr_err_i ? 1'b0 : m_tmo);
    m_unexp = uset ? 1'b1 : (clr_err_i ? 1'b0 : m_unexp);
    m_rv = rv;
    if (rv) m_rd = mst_resp_i.rdata;
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input int n);
    auto_rsp = 1'b1; rsp_pct = 100;
    for (int i = 0; i < n; i++) begin
      idle(1'b1);
      step();
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req"},    64'(mst_req_o.req),     64'(0));
    check({tag, "_addr"},   64'(mst_req_o.addr),    64'(0));
    check({tag, "_wdata"},  64'(mst_req_o.wdata),   64'(0));
    check({tag, "_rvalid"}, 64'(slv_resp_o.rvalid), 64'(0));
    check({tag, "_rdata"},  64'(slv_resp_o.rdata),  64'(0));
    check({tag, "_cnt"},    64'(outstanding_o),     64'(0));
    check({tag, "_tmo"},    64'(timeout_o),         64'(0));
    check({tag, "_unexp"},  64'(unexp_rvalid_o),    64'(0));
  endtask

  initial begin
    int acc0, k;
    cyc = 0; peak = 0; accepted = 0;
    auto_rsp = 1'b0; rsp_pct = 100; dly_lo = 2; dly_hi = 2;
    model_reset();
    idle(1'b0);
    #12;
    reset_checks("por");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Single read
    drive(1'b1, 1'b0, 4'hF, 32'h2000_0010, 32'h0, 1'b0, 1'b0); step();
    idle(1'b1); step();
    idle(1'b0); step();
    idle(1'b0); force_rv(32'hDEAD_BEEF); step();
    idle(1'b0); step();
    check("rd_rdata", 64'(slv_resp_o.rdata), 64'(32'hDEAD_BEEF));

    // Back-to-back writes, response two cycles after each grant
    auto_rsp = 1'b1; rsp_pct = 100; dly_lo = 2; dly_hi = 2;
    peak = 0; acc0 = accepted;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 4'(i + 1), 32'h1000 + 32'(4 * i), $urandom, 1'b1, 1'b0);
      step();
    end
    drain(6);
    check("b2b_accepted", 64'(accepted - acc0), 64'(8));
    check("b2b_peak", 64'(peak), 64'(2));

    // Downstream stall
    acc0 = accepted;
    for (int i = 0; i < 6; i++) begin
      rnd_req(1'b0);
      step();
    end
    check("stall_accepted", 64'(accepted - acc0), 64'(1));
    rnd_req(1'b1); step();
    check("stall_resume", 64'(accepted - acc0), 64'(2));
    drain(8);

    // Outstanding cap, then one response releases the fifth request
    auto_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rnd_req(1'b1);
      step();
    end
    check("cap_cnt", 64'(outstanding_o), 64'(MAXO));
    check("cap_req", 64'(mst_req_o.req), 64'(0));
    idle(1'b1); force_rv(32'h1234_5678); step();
    idle(1'b1); step();
    drain(12);

    // Watchdog, with a clear in the expiry cycle that must lose
    auto_rsp = 1'b0;
    rnd_req(1'b0); step();
    idle(1'b1); step();
    for (k = 1; k <= 40; k++) begin
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, k == 14);
      step();
      if (obs_tmo) break;
    end
    check("wdog_latency", 64'(k), 64'(15));
    for (int i = 0; i < 3; i++) begin idle(1'b0); step(); end
    idle(1'b0); force_rv(32'h0BAD_F00D); step();
    idle(1'b0); step();
    check("wdog_sticky", 64'(timeout_o), 64'(1));
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1); step();
    idle(1'b0); step();
    check("wdog_clear", 64'(timeout_o), 64'(0));

    // Unexpected rvalid, then reset in the middle of traffic
    idle(1'b0); force_rv(32'hCAFE_F00D); step();
    idle(1'b0); step();
    check("unexp_flag", 64'(unexp_rvalid_o), 64'(1));
    auto_rsp = 1'b1; rsp_pct = 100; dly_lo = 3; dly_hi = 3;
    for (int i = 0; i < 3; i++) begin rnd_req(1'b1); step(); end
    #2;
    rst_ni = 1'b0;
    #1;
    reset_checks("arst");
    model_reset();
    @(posedge clk_i);
    cyc++;
    #1;
    rst_ni = 1'b1;
    drain(6);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1); step();

    // Random traffic
    auto_rsp = 1'b1; rsp_pct = 60; dly_lo = 1; dly_hi = 6;
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 7, 1'($urandom), 4'($urandom), $urandom, $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      step();
    end
    drain(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
